pdp1_sbs16: RTL and testbench
=============================

Name: pdp1_sbs16

Overview:
- Multi-channel priority sequence-break controller. It replaces the single-level break flag with 16 armable channels, modelled on the PDP-1 Type 120.
- Latches device break requests, arbitrates by fixed priority (channel 0 highest) and presents one break request plus channel number to the CPU.
- Tracks nested active breaks and is configured by IOT instructions on the peripheral bus.

Parameters:
- NCHAN, 16, number of break channels; channel 0 is highest priority.
- CHW, 4, width of a channel number; must satisfy 2**CHW >= NCHAN.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset, asynchronous, active-high.
- pb_att  in  1  IOT strobe; pb_op and pb_ac are valid this cycle.
- pb_op  in  [0:10]  IOT opcode.
- pb_ac  in  [0:17]  AC contents; channel operand in pb_ac[18-CHW:17].
- tr_req  in  [0:NCHAN-1]  device break request levels, one per channel.
- sb_ireq  out  1  break request to CPU, registered.
- sb_chan  out  CHW  channel of the requested break; stable while sb_ireq=1.
- sb_ack  in  1  CPU has entered the break cycle for sb_chan.
- sb_dne  in  1  CPU has executed a debreak (jmp restore).
- pb_sqb  out  [0:NCHAN-1]  pending-request flags for status readback.
- sb_act  out  [0:NCHAN-1]  active (in-service) channel flags.

Behaviour:
- Reset (async): r_en=0, arm=0, pend=0, act=0, prev_req=0, state=IDLE, sb_ireq=0, sb_chan=0.
- Edge detection:
  - prev_req registers tr_req every cycle.
  - A rising edge (tr_req & ~prev_req) on channel c sets pend[c].
  - Held levels do not re-request.
- IOT ops are acted on only when pb_att=1; unlisted opcodes are ignored. Channel operand is ch.
  - ESM 0055: r_en<=1.
  - LSM 0054: r_en<=0.
  - CBS 0056: pend<=0.
  - DSC 0050: arm[ch]<=0.
  - ASC 0051: arm[ch]<=1.
  - ISB 0052: pend[ch]<=1 (software break).
  - CAC 0053: arm<=0.
  - If ch>=NCHAN, the IOT is ignored.
- Eligibility:
  - elig[c] = r_en & arm[c] & pend[c] & (no act[k] set for any k<=c).
  - winner = lowest-index set bit of elig.
- FSM, two states:
  - IDLE: if any elig, then sb_chan<=winner, sb_ireq<=1, go to REQ; otherwise stay.
  - REQ on sb_ack: pend[sb_chan]<=0, act[sb_chan]<=1, sb_ireq<=0, go to IDLE.
  - REQ when elig[sb_chan]=0 and no ack (cancelled by LSM, DSC, CBS, CAC or a new act): sb_ireq<=0, go to IDLE, rescan next cycle.
  - A higher-priority channel arriving during REQ does not preempt; it wins the scan after ack and nests.
- Latency:
  - Edge sampled at clock k sets pend after k.
  - sb_ireq=1 after clock k+1, i.e. 2 cycles from request to ireq.
  - After ack, the next break can be requested no earlier than 2 cycles later.
- sb_dne clears the lowest-index set bit of act. With act=0 it is ignored.
- sb_ack outside REQ is ignored.
- Simultaneous events:
  - Rising edge and ack/CBS on the same channel: the set wins, so the new request is kept pending.
  - ISB and CBS in the same IOT cycle cannot occur (single opcode).
  - sb_dne and sb_ack in the same cycle: clear is computed on the old act, then the ack bit is set.
  - IOT and a FSM transition in the same cycle: both register updates apply. Eligibility uses the pre-update values; cancellation is seen the next cycle.
- Reset mid-REQ: sb_ireq drops asynchronously; all state is lost.

Decomposition:
- Package pdp1_sbs_pkg:
  - IOT opcode constants (ESM, LSM, CBS, DSC, ASC, ISB, CAC).
  - FSM state encoding.
  - Default NCHAN/CHW.
- Sub-module pdp1_sbs_prienc: parameterized lowest-set-bit encoder producing an index and an any flag. Instantiated twice, for the elig winner and the act clear.

Test Plan:
- ESM, ASC ch=3, tr_req[3] rises at clock k -> sb_ireq=1, sb_chan=3 after k+1; sb_ack -> sb_ireq=0, sb_act[3]=1, pb_sqb[3]=0.
- Nesting:
  - With ch3 active, arm ch1 and ch7 and pulse both -> ch1 requested and acked, act={1,3}.
  - ch7 is not requested until two sb_dne pulses (first clears ch1, second clears ch3).
  - ch7 is requested 2 cycles after the second dne.
- Cancel: ch5 in REQ, issue DSC ch=5 -> sb_ireq falls the next cycle, state IDLE; pb_sqb[5] stays 1; ASC ch=5 re-raises the request.
- LSM with pending ch0 -> no sb_ireq; ISB ch=2 while disabled -> pb_sqb[2]=1; ESM -> ch0 is requested first, ch2 after ack.
- Same-cycle: tr_req[4] rising edge while ch4 is acked -> act[4]=1 and pb_sqb[4]=1; sb_dne+sb_ack together -> old highest act cleared and acked channel set.
- Assert i_rst asynchronously mid-REQ -> sb_ireq=0 immediately, all flags 0; a held tr_req level after reset does not request until it toggles low then high.

Source files
------------

// File: rtl/pdp1_sbs_pkg.sv
// rtl/pdp1_sbs_pkg.sv - shared constants and types for the sequence-break controller
package pdp1_sbs_pkg;

   // Default channel count and channel-number width
   localparam int NCHAN_DEF = 16;
   localparam int CHW_DEF   = 4;

   // IOT opcodes recognised by the controller
   localparam logic [0:10] OP_DSC = 11'o0050;
   localparam logic [0:10] OP_ASC = 11'o0051;
   localparam logic [0:10] OP_ISB = 11'o0052;
   localparam logic [0:10] OP_CAC = 11'o0053;
   localparam logic [0:10] OP_LSM = 11'o0054;
   localparam logic [0:10] OP_ESM = 11'o0055;
   localparam logic [0:10] OP_CBS = 11'o0056;

   // Break handshake states
   typedef enum logic {
      S_IDLE = 1'b0,
      S_REQ  = 1'b1
   } sbs_state_t;

endpackage

// File: rtl/pdp1_sbs_prienc.sv
// rtl/pdp1_sbs_prienc.sv - lowest-index set-bit encoder
module pdp1_sbs_prienc #(
   parameter int N = 16,
   parameter int W = 4
) (
   input  logic [0:N-1] vec,
   output logic [W-1:0] idx,
   output logic         found
);

   // Scan from the top so the lowest set index is written last and wins
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) idx = W'(i);
      end
      found = |vec;
   end

endmodule

// File: rtl/pdp1_sbs16.sv
// rtl/pdp1_sbs16.sv - 16-channel priority sequence-break controller
module pdp1_sbs16
   import pdp1_sbs_pkg::*;
#(
   parameter int NCHAN = NCHAN_DEF,
   parameter int CHW   = CHW_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             pb_att,
   input  logic [0:10]      pb_op,
   input  logic [0:17]      pb_ac,
   input  logic [0:NCHAN-1] tr_req,
   output logic             sb_ireq,
   output logic [CHW-1:0]   sb_chan,
   input  logic             sb_ack,
   input  logic             sb_dne,
   output logic [0:NCHAN-1] pb_sqb,
   output logic [0:NCHAN-1] sb_act
);

   logic             r_en, r_en_nxt;
   logic [0:NCHAN-1] arm, arm_nxt;
   logic [0:NCHAN-1] pend, pend_nxt;
   logic [0:NCHAN-1] act, act_nxt;
   logic [0:NCHAN-1] prev_req;
   logic [0:NCHAN-1] rise;
   logic [0:NCHAN-1] elig;
   logic             blk;
   logic [CHW-1:0]   ch;
   logic             ch_ok;
   logic [CHW-1:0]   win_idx, clr_idx;
   logic             win_any, act_any;
   sbs_state_t       state, state_nxt;
   logic [CHW-1:0]   chan_nxt;
   logic             ack_take;
   logic             unused_ac;

   assign ch        = pb_ac[18-CHW:17];
   assign ch_ok     = (32'(ch) < NCHAN);
   assign unused_ac = ^pb_ac[0:17-CHW];
   assign rise      = tr_req & ~prev_req;

   // A channel is eligible only if nothing of equal or higher priority is in service
   always_comb begin
      blk  = 1'b0;
      elig = '0;
      for (int c = 0; c < NCHAN; c++) begin
         blk     = blk | act[c];
         elig[c] = r_en & arm[c] & pend[c] & ~blk;
      end
   end

   pdp1_sbs_prienc #(.N(NCHAN), .W(CHW)) u_win (
      .vec   (elig),
      .idx   (win_idx),
      .found (win_any)
   );

   pdp1_sbs_prienc #(.N(NCHAN), .W(CHW)) u_clr (
      .vec   (act),
      .idx   (clr_idx),
      .found (act_any)
   );

   // Handshake next state: scan in IDLE, wait for ack or cancellation in REQ
   always_comb begin
      state_nxt = state;
      chan_nxt  = sb_chan;
      ack_take  = 1'b0;
      case (state)
         S_IDLE: begin
            if (win_any) begin
               chan_nxt  = win_idx;
               state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (sb_ack) begin
               ack_take  = 1'b1;
               state_nxt = S_IDLE;
            end else if (!elig[sb_chan]) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Handshake state and latched channel number
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= S_IDLE;
         sb_chan <= '0;
      end else begin
         state   <= state_nxt;
         sb_chan <= chan_nxt;
      end
   end

   assign sb_ireq = (state == S_REQ);

   // Flag updates: IOT effects and ack clears first, then new edges so a set always wins
   always_comb begin
      r_en_nxt = r_en;
      arm_nxt  = arm;
      pend_nxt = pend;
      act_nxt  = act;
      if (pb_att && ch_ok) begin
         case (pb_op)
            OP_ESM:  r_en_nxt     = 1'b1;
            OP_LSM:  r_en_nxt     = 1'b0;
            OP_CBS:  pend_nxt     = '0;
            OP_DSC:  arm_nxt[ch]  = 1'b0;
            OP_ASC:  arm_nxt[ch]  = 1'b1;
            OP_ISB:  pend_nxt[ch] = 1'b1;
            OP_CAC:  arm_nxt      = '0;
            default: ;
         endcase
      end
      if (ack_take) pend_nxt[sb_chan] = 1'b0;
      pend_nxt = pend_nxt | rise;
      if (sb_dne && act_any) act_nxt[clr_idx] = 1'b0;
      if (ack_take) act_nxt[sb_chan] = 1'b1;
   end

   // Configuration, pending, active and request-history registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_en     <= 1'b0;
         arm      <= '0;
         pend     <= '0;
         act      <= '0;
         prev_req <= '0;
      end else begin
         r_en     <= r_en_nxt;
         arm      <= arm_nxt;
         pend     <= pend_nxt;
         act      <= act_nxt;
         prev_req <= tr_req;
      end
   end

   assign pb_sqb = pend;
   assign sb_act = act;

endmodule

// File: tb/tb_pdp1_sbs16.sv
// tb/tb_pdp1_sbs16.sv - self-checking bench for pdp1_sbs16
module tb_pdp1_sbs16;

   localparam logic [0:10] DSC = 11'o0050;
   localparam logic [0:10] ASC = 11'o0051;
   localparam logic [0:10] ISB = 11'o0052;
   localparam logic [0:10] CAC = 11'o0053;
   localparam logic [0:10] LSM = 11'o0054;
   localparam logic [0:10] ESM = 11'o0055;
   localparam logic [0:10] CBS = 11'o0056;
   localparam logic [0:10] BAD = 11'o0057;
   localparam logic [0:10] NOP = 11'o0000;
   localparam logic [0:15] Z   = 16'h0000;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        pb_att = 1'b0;
   logic [0:10] pb_op = '0;
   logic [0:17] pb_ac = '0;
   logic [0:15] tr_req = '0;
   logic        sb_ireq;
   logic [3:0]  sb_chan;
   logic        sb_ack = 1'b0;
   logic        sb_dne = 1'b0;
   logic [0:15] pb_sqb;
   logic [0:15] sb_act;

   pdp1_sbs16 dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .pb_att  (pb_att),
      .pb_op   (pb_op),
      .pb_ac   (pb_ac),
      .tr_req  (tr_req),
      .sb_ireq (sb_ireq),
      .sb_chan (sb_chan),
      .sb_ack  (sb_ack),
      .sb_dne  (sb_dne),
      .pb_sqb  (pb_sqb),
      .sb_act  (sb_act)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic        att;
      logic [0:10] op;
      int          ch;
      logic [0:15] tr;
      logic        ack;
      logic        dne;
      logic        e_ireq;
      int          e_chan;
      logic [0:15] e_sqb;
      logic [0:15] e_act;
   } vec_t;

   typedef struct {
      logic        ireq;
      logic [3:0]  chan;
      logic [0:15] sqb;
      logic [0:15] act;
      int          tag;
   } exp_t;

   vec_t vecs[$];
   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic logic [0:15] bm(input int c);
      logic [0:15] m;
      m    = '0;
      m[c] = 1'b1;
      return m;
   endfunction

   task automatic chk(input string name, input int tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h required %h", name, tag, got, exp);
      end
   endtask

   task automatic add(input logic att, input logic [0:10] op, input int ch, input logic [0:15] tr,
                      input logic ack, input logic dne, input logic e_ireq, input int e_chan,
                      input logic [0:15] e_sqb, input logic [0:15] e_act);
      vec_t v;
      v.att = att; v.op = op; v.ch = ch; v.tr = tr; v.ack = ack; v.dne = dne;
      v.e_ireq = e_ireq; v.e_chan = e_chan; v.e_sqb = e_sqb; v.e_act = e_act;
      vecs.push_back(v);
   endtask

   task automatic cycle(input vec_t v, input int tag);
      exp_t e, g;
      pb_att = v.att;
      pb_op  = v.op;
      pb_ac  = 18'(v.ch);
      tr_req = v.tr;
      sb_ack = v.ack;
      sb_dne = v.dne;
      e.ireq = v.e_ireq; e.chan = 4'(v.e_chan); e.sqb = v.e_sqb; e.act = v.e_act; e.tag = tag;
      sb_q.push_back(e);
      @(posedge i_clk);
      #1;
      g = sb_q.pop_front();
      chk("sb_ireq", g.tag, 32'(sb_ireq), 32'(g.ireq));
      chk("sb_chan", g.tag, 32'(sb_chan), 32'(g.chan));
      chk("pb_sqb",  g.tag, 32'(pb_sqb),  32'(g.sqb));
      chk("sb_act",  g.tag, 32'(sb_act),  32'(g.act));
   endtask

   initial begin
      vec_t h;
      // basic request and ack on channel 3
      add(1, ESM, 0, Z,      0, 0,  0, 0, Z, Z);
      add(1, ASC, 3, Z,      0, 0,  0, 0, Z, Z);
      add(0, NOP, 0, bm(3),  0, 0,  0, 0, bm(3), Z);
      add(0, NOP, 0, bm(3),  0, 0,  1, 3, bm(3), Z);
      add(0, NOP, 0, bm(3),  1, 0,  0, 3, Z, bm(3));
      add(0, NOP, 0, Z,      1, 0,  0, 3, Z, bm(3));
      // nesting: ch1 over active ch3, ch7 waits for two debreaks
      add(1, ASC, 1, Z,      0, 0,  0, 3, Z, bm(3));
      add(1, ASC, 7, Z,      0, 0,  0, 3, Z, bm(3));
      add(0, NOP, 0, bm(1)|bm(7), 0, 0,  0, 3, bm(1)|bm(7), bm(3));
      add(0, NOP, 0, Z,      0, 0,  1, 1, bm(1)|bm(7), bm(3));
      add(0, NOP, 0, Z,      1, 0,  0, 1, bm(7), bm(1)|bm(3));
      add(0, NOP, 0, Z,      0, 0,  0, 1, bm(7), bm(1)|bm(3));
      add(0, NOP, 0, Z,      0, 1,  0, 1, bm(7), bm(3));
      add(0, NOP, 0, Z,      0, 0,  0, 1, bm(7), bm(3));
      add(0, NOP, 0, Z,      0, 1,  0, 1, bm(7), Z);
      add(0, NOP, 0, Z,      0, 0,  1, 7, bm(7), Z);
      add(0, NOP, 0, Z,      1, 0,  0, 7, Z, bm(7));
      add(0, NOP, 0, Z,      0, 1,  0, 7, Z, Z);
      // cancel by DSC, re-raise by ASC; dne with nothing active
      add(1, ASC, 5, Z,      0, 1,  0, 7, Z, Z);
      add(0, NOP, 0, bm(5),  0, 0,  0, 7, bm(5), Z);
      add(0, NOP, 0, bm(5),  0, 0,  1, 5, bm(5), Z);
      add(1, DSC, 5, bm(5),  0, 0,  1, 5, bm(5), Z);
      add(0, NOP, 0, Z,      0, 0,  0, 5, bm(5), Z);
      add(1, ASC, 5, Z,      0, 0,  0, 5, bm(5), Z);
      add(0, NOP, 0, Z,      0, 0,  1, 5, bm(5), Z);
      add(0, NOP, 0, Z,      1, 0,  0, 5, Z, bm(5));
      add(0, NOP, 0, Z,      0, 1,  0, 5, Z, Z);
      // disabled system: pending and software breaks held until ESM
      add(1, ASC, 0, Z,      0, 0,  0, 5, Z, Z);
      add(1, LSM, 0, Z,      0, 0,  0, 5, Z, Z);
      add(0, NOP, 0, bm(0),  0, 0,  0, 5, bm(0), Z);
      add(0, NOP, 0, bm(0),  0, 0,  0, 5, bm(0), Z);
      add(1, ASC, 2, Z,      0, 0,  0, 5, bm(0), Z);
      add(1, ISB, 2, Z,      0, 0,  0, 5, bm(0)|bm(2), Z);
      add(0, ESM, 0, Z,      0, 0,  0, 5, bm(0)|bm(2), Z);
      add(1, ESM, 0, Z,      0, 0,  0, 5, bm(0)|bm(2), Z);
      add(0, NOP, 0, Z,      0, 0,  1, 0, bm(0)|bm(2), Z);
      add(0, NOP, 0, Z,      1, 0,  0, 0, bm(2), bm(0));
      add(0, NOP, 0, Z,      0, 1,  0, 0, bm(2), Z);
      add(0, NOP, 0, Z,      0, 0,  1, 2, bm(2), Z);
      add(0, NOP, 0, Z,      1, 0,  0, 2, Z, bm(2));
      add(0, NOP, 0, Z,      0, 1,  0, 2, Z, Z);
      // new edge on the channel being acked stays pending
      add(1, ASC, 4, Z,      0, 0,  0, 2, Z, Z);
      add(0, NOP, 0, bm(4),  0, 0,  0, 2, bm(4), Z);
      add(0, NOP, 0, Z,      0, 0,  1, 4, bm(4), Z);
      add(0, NOP, 0, bm(4),  1, 0,  0, 4, bm(4), bm(4));
      add(0, NOP, 0, Z,      0, 0,  0, 4, bm(4), bm(4));
      // dne and ack together
      add(0, NOP, 0, bm(1),  0, 0,  0, 4, bm(1)|bm(4), bm(4));
      add(0, NOP, 0, Z,      0, 0,  1, 1, bm(1)|bm(4), bm(4));
      add(0, NOP, 0, Z,      1, 1,  0, 1, bm(4), bm(1));
      add(0, NOP, 0, Z,      0, 1,  0, 1, bm(4), Z);
      add(0, NOP, 0, Z,      0, 0,  1, 4, bm(4), Z);
      // CBS cancel, CAC, unlisted opcode
      add(1, CBS, 0, Z,      0, 0,  1, 4, Z, Z);
      add(0, NOP, 0, Z,      0, 0,  0, 4, Z, Z);
      add(1, CAC, 0, Z,      0, 0,  0, 4, Z, Z);
      add(1, ISB, 1, Z,      0, 0,  0, 4, bm(1), Z);
      add(0, NOP, 0, Z,      0, 0,  0, 4, bm(1), Z);
      add(1, BAD, 1, Z,      0, 0,  0, 4, bm(1), Z);

      // reset state
      #2;
      chk("rst_ireq", 0, 32'(sb_ireq), 32'd0);
      chk("rst_chan", 0, 32'(sb_chan), 32'd0);
      chk("rst_sqb",  0, 32'(pb_sqb),  32'd0);
      chk("rst_act",  0, 32'(sb_act),  32'd0);
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) cycle(vecs[i], i + 1);

      // reach REQ on ch1 with ch6 held high, then reset mid-cycle
      h = '{1'b1, ASC, 1, Z, 1'b0, 1'b0, 1'b0, 4, bm(1), Z};
      cycle(h, 100);
      h = '{1'b0, NOP, 0, bm(6), 1'b0, 1'b0, 1'b1, 1, bm(1)|bm(6), Z};
      cycle(h, 101);
      #3;
      i_rst = 1'b1;
      #1;
      chk("arst_ireq", 102, 32'(sb_ireq), 32'd0);
      chk("arst_chan", 102, 32'(sb_chan), 32'd0);
      chk("arst_sqb",  102, 32'(pb_sqb),  32'd0);
      chk("arst_act",  102, 32'(sb_act),  32'd0);
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;

      // held level: cleared once, then only a fresh low-high edge requests
      h = '{1'b1, ESM, 0, bm(6), 1'b0, 1'b0, 1'b0, 0, bm(6), Z};
      cycle(h, 103);
      h = '{1'b1, CBS, 0, bm(6), 1'b0, 1'b0, 1'b0, 0, Z, Z};
      cycle(h, 104);
      h = '{1'b1, ASC, 6, bm(6), 1'b0, 1'b0, 1'b0, 0, Z, Z};
      cycle(h, 105);
      h = '{1'b0, NOP, 0, bm(6), 1'b0, 1'b0, 1'b0, 0, Z, Z};
      cycle(h, 106);
      cycle(h, 107);
      h = '{1'b0, NOP, 0, Z, 1'b0, 1'b0, 1'b0, 0, Z, Z};
      cycle(h, 108);
      h = '{1'b0, NOP, 0, bm(6), 1'b0, 1'b0, 1'b0, 0, bm(6), Z};
      cycle(h, 109);
      h = '{1'b0, NOP, 0, bm(6), 1'b0, 1'b0, 1'b1, 6, bm(6), Z};
      cycle(h, 110);

      chk("sb_queue_empty", 111, 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
